memwb_stage: RTL and testbench
==============================

Name: memwb_stage

Overview:
- Write-back pipeline stage directly downstream of the memory-access stage.
- Latches the memory stage's outputs every cycle, supporting stall (hold) and flush (bubble).
- Aligns and sign-extends load data returned from the synchronous data memory.
- Owns the architectural HI/LO registers and drives the register-file write port plus the write-back forwarding path to decode.

Parameters:
- REG_W, 32, general register / data width
- ADDR_W, 5, register address width
- HILO_RST, 64'h0, reset value of {HI,LO}

Ports:
- cpu_clk_50M  in  1  system clock, rising-edge
- cpu_rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold WB latch contents
- flush  in  1  replace latched instruction with bubble
- mem_wa_i  in  ADDR_W  destination register from MEM
- mem_wreg_i  in  1  register write enable from MEM
- mem_whilo_i  in  1  HI/LO write enable from MEM
- mem_mreg_i  in  1  result comes from memory (load)
- mem_dreg_i  in  REG_W  ALU/address result from MEM
- mem_dhilo_i  in  2*REG_W  {HI,LO} result from MEM
- mem_dre_i  in  4  byte read enables from MEM
- dm  in  REG_W  data-memory read word; valid the cycle after the request
- wb_wa_o  out  ADDR_W  regfile write address
- wb_wreg_o  out  1  regfile write enable
- wb_wd_o  out  REG_W  regfile write data (also forwarded to decode)
- hi_o  out  REG_W  architectural HI
- lo_o  out  REG_W  architectural LO

Behaviour:
- Reset: async on cpu_rst=1. All latch fields are 0, fresh_q=0, dm_q=0, {HI,LO}=HILO_RST. wb_wreg_o=0, wb_wa_o=0, wb_wd_o=0.
- Latch update on each rising edge, in priority order:
  - flush=1: wreg_q, whilo_q, mreg_q, dre_q, wa_q, dreg_q and dhilo_q all cleared to 0. Flush beats stall.
  - Else stall=1: all latch fields hold.
  - Else: all fields load from the mem_*_i inputs.
- fresh_q:
  - Set to 1 on an edge that loads new content with mem_mreg_i=1.
  - Cleared to 0 on every other edge: stall, flush, or a load with mreg=0.
- dm_q captures dm on any edge where fresh_q=1 (first WB cycle of a load).
- Load data source: ld = fresh_q ? dm : dm_q. Load data stays stable across stall even if the memory output changes.
- Memory word byte order: byte at address offset 0 is ld[31:24]; offset 3 is ld[7:0].
- Write data when mreg_q=1, decoded from dre_q:
  - 4'b1111 (LW): {ld[7:0], ld[15:8], ld[23:16], ld[31:24]}
  - 4'b1000 (LB): sign-extend ld[31:24]
  - 4'b0100 (LB): sign-extend ld[23:16]
  - 4'b0010 (LB): sign-extend ld[15:8]
  - 4'b0001 (LB): sign-extend ld[7:0]
  - any other code: 0
- Write data when mreg_q=0: dreg_q.
- wb_wd_o, wb_wa_o and wb_wreg_o are combinational from the latch. Zero latency from the latch to the regfile port; the regfile writes at the next edge.
- HI/LO:
  - On a rising edge with whilo_q=1 and not in reset: HI<=dhilo_q[63:32], LO<=dhilo_q[31:0].
  - The write is idempotent under stall: a held instruction rewrites the same value.
  - A flush on the same edge does not cancel the write, because whilo_q reflects the instruction already in WB.
- Simultaneous stall and flush: flush wins, producing a bubble.
- Reset mid-load: fresh_q and dm_q are cleared, and no write is issued after reset release until a new instruction is latched.

Optional Feature:
- Macro WB_HILO_BYPASS_EN.
- Defined: hi_o/lo_o = whilo_q ? dhilo_q halves : HI/LO registers, so the value being committed is visible in the same cycle.
- Undefined: hi_o/lo_o are driven purely from the registers, so a new value is visible one cycle after WB.

Test Plan:
- Reset: hold cpu_rst=1 with random inputs -> wb_wreg_o=0, wb_wd_o=0, hi_o=lo_o=0. Deassert -> outputs stay 0 until the first latch edge.
- LW: mreg=1, dre=4'b1111, wa=5'd8; next cycle dm=32'h78563412 -> wb_wd_o=32'h12345678, wb_wreg_o=1, wb_wa_o=8.
- LB sign: dre=4'b0100, dm=32'h00F00000 -> wb_wd_o=32'hFFFFFFF0. Repeat with dre=4'b0001, dm=32'h0000007F -> 32'h0000007F.
- Stall during load: LW latched, dm=32'hAABBCCDD in first cycle, then stall=1 for 3 cycles while dm changes to 32'h0 -> wb_wd_o stays 32'hDDCCBBAA throughout.
- Flush with stall: stall=1 and flush=1 on the same edge with an ALU write pending -> next cycle wb_wreg_o=0, wb_wd_o=0.
- HI/LO: whilo=1, dhilo=64'h00000001_FFFFFFFE -> hi_o=1, lo_o=32'hFFFFFFFE one edge after the WB cycle. With WB_HILO_BYPASS_EN the values appear during the WB cycle itself.

Source files
------------

// File: rtl/memwb_stage.sv
// Write-back stage: latches MEM results, aligns/sign-extends load data, owns HI/LO.
// Latency: regfile port is combinational from the WB latch; HI/LO registers update one edge after WB.
// Backpressure: stall holds the latch, flush inserts a bubble and wins over stall; optional WB_HILO_BYPASS_EN.
module memwb_stage #(
    parameter int                   REG_W    = 32,
    parameter int                   ADDR_W   = 5,
    parameter logic [2*REG_W-1:0]   HILO_RST = '0
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     mem_wa_i,
    input  logic                  mem_wreg_i,
    input  logic                  mem_whilo_i,
    input  logic                  mem_mreg_i,
    input  logic [REG_W-1:0]      mem_dreg_i,
    input  logic [2*REG_W-1:0]    mem_dhilo_i,
    input  logic [3:0]            mem_dre_i,
    input  logic [REG_W-1:0]      dm,
    output logic [ADDR_W-1:0]     wb_wa_o,
    output logic                  wb_wreg_o,
    output logic [REG_W-1:0]      wb_wd_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o
);

    logic [ADDR_W-1:0]   wa_q;
    logic                wreg_q;
    logic                whilo_q;
    logic                mreg_q;
    logic [REG_W-1:0]    dreg_q;
    logic [2*REG_W-1:0]  dhilo_q;
    logic [3:0]          dre_q;
    logic                fresh_q;
    logic [REG_W-1:0]    dm_q;
    logic [REG_W-1:0]    hi_q;
    logic [REG_W-1:0]    lo_q;

    logic [REG_W-1:0]    ld;
    logic [REG_W-1:0]    load_wd;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            wa_q    <= '0;
            wreg_q  <= 1'b0;
            whilo_q <= 1'b0;
            mreg_q  <= 1'b0;
            dreg_q  <= '0;
            dhilo_q <= '0;
            dre_q   <= '0;
        end else if (flush) begin
            wa_q    <= '0;
            wreg_q  <= 1'b0;
            whilo_q <= 1'b0;
            mreg_q  <= 1'b0;
            dreg_q  <= '0;
            dhilo_q <= '0;
            dre_q   <= '0;
        end else if (!stall) begin
            wa_q    <= mem_wa_i;
            wreg_q  <= mem_wreg_i;
            whilo_q <= mem_whilo_i;
            mreg_q  <= mem_mreg_i;
            dreg_q  <= mem_dreg_i;
            dhilo_q <= mem_dhilo_i;
            dre_q   <= mem_dre_i;
        end
    end

    // The memory word is only guaranteed valid during the first WB cycle of a load,
    // so it is snapshotted then and replayed for as long as the stage is held.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            fresh_q <= 1'b0;
            dm_q    <= '0;
        end else begin
            fresh_q <= !flush && !stall && mem_mreg_i;
            if (fresh_q) begin
                dm_q <= dm;
            end
        end
    end

    // A write already in WB commits even if a flush arrives on the same edge.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            hi_q <= HILO_RST[2*REG_W-1:REG_W];
            lo_q <= HILO_RST[REG_W-1:0];
        end else if (whilo_q) begin
            hi_q <= dhilo_q[2*REG_W-1:REG_W];
            lo_q <= dhilo_q[REG_W-1:0];
        end
    end

    assign ld = fresh_q ? dm : dm_q;

    // Memory is big-endian by address offset: offset 0 lives in ld[31:24].
    always_comb begin
        load_wd = '0;
        case (dre_q)
            4'b1111: load_wd = {ld[7:0], ld[15:8], ld[23:16], ld[31:24]};
            4'b1000: load_wd = {{(REG_W-8){ld[31]}}, ld[31:24]};
            4'b0100: load_wd = {{(REG_W-8){ld[23]}}, ld[23:16]};
            4'b0010: load_wd = {{(REG_W-8){ld[15]}}, ld[15:8]};
            4'b0001: load_wd = {{(REG_W-8){ld[7]}},  ld[7:0]};
            default: load_wd = '0;
        endcase
    end

    assign wb_wa_o   = wa_q;
    assign wb_wreg_o = wreg_q;
    assign wb_wd_o   = mreg_q ? load_wd : dreg_q;

`ifdef WB_HILO_BYPASS_EN
    assign hi_o = whilo_q ? dhilo_q[2*REG_W-1:REG_W] : hi_q;
    assign lo_o = whilo_q ? dhilo_q[REG_W-1:0]       : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Directed bench for memwb_stage: regfile-port results go through an expected-value queue.
module tb_memwb_stage;

    typedef struct packed {
        logic        wreg;
        logic [4:0]  wa;
        logic [31:0] wd;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [4:0]  mem_wa_i;
    logic        mem_wreg_i;
    logic        mem_whilo_i;
    logic        mem_mreg_i;
    logic [31:0] mem_dreg_i;
    logic [63:0] mem_dhilo_i;
    logic [3:0]  mem_dre_i;
    logic [31:0] dm;
    logic [4:0]  wb_wa_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wd_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;
    wb_t exp_q[$];

    memwb_stage dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .stall       (stall),
        .flush       (flush),
        .mem_wa_i    (mem_wa_i),
        .mem_wreg_i  (mem_wreg_i),
        .mem_whilo_i (mem_whilo_i),
        .mem_mreg_i  (mem_mreg_i),
        .mem_dreg_i  (mem_dreg_i),
        .mem_dhilo_i (mem_dhilo_i),
        .mem_dre_i   (mem_dre_i),
        .dm          (dm),
        .wb_wa_o     (wb_wa_o),
        .wb_wreg_o   (wb_wreg_o),
        .wb_wd_o     (wb_wd_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] wa, input logic wreg, input logic whilo,
                         input logic mreg, input logic [31:0] dreg,
                         input logic [63:0] dhilo, input logic [3:0] dre);
        mem_wa_i    = wa;
        mem_wreg_i  = wreg;
        mem_whilo_i = whilo;
        mem_mreg_i  = mreg;
        mem_dreg_i  = dreg;
        mem_dhilo_i = dhilo;
        mem_dre_i   = dre;
        stall       = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic idle();
        drive(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 4'b0000);
    endtask

    task automatic expect_wb(input logic wreg, input logic [4:0] wa, input logic [31:0] wd);
        wb_t e;
        e.wreg = wreg;
        e.wa   = wa;
        e.wd   = wd;
        exp_q.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_t obs;
        wb_t e;
        obs = {wb_wreg_o, wb_wa_o, wb_wd_o};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: no expected entry queued, observed wreg=%0b wa=%0d wd=%h",
                   tag, obs.wreg, obs.wa, obs.wd);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed wreg=%0b wa=%0d wd=%h, expected wreg=%0b wa=%0d wd=%h",
                       tag, obs.wreg, obs.wa, obs.wd, e.wreg, e.wa, e.wd);
            end
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        checks++;
        assert ({hi_o, lo_o} === {hi, lo}) else begin
            errors++;
            $error("FAIL %s: observed hi=%h lo=%h, expected hi=%h lo=%h", tag, hi_o, lo_o, hi, lo);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        dm = 32'h0;

        // Reset held with random activity on every input.
        for (int i = 0; i < 4; i++) begin
            drive(5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, {$urandom, $urandom}, 4'($urandom));
            stall = 1'($urandom);
            flush = 1'($urandom);
            dm    = $urandom;
            tick();
        end
        expect_wb(1'b0, 5'd0, 32'h0);
        check_wb("reset_outputs");
        check_hilo("reset_hilo", 32'h0, 32'h0);

        idle();
        #2;
        rst = 1'b0;
        #1;
        expect_wb(1'b0, 5'd0, 32'h0);
        check_wb("post_reset_before_edge");

        // LW with byte reversal.
        drive(5'd8, 1'b1, 1'b0, 1'b1, 32'h100, 64'h0, 4'b1111);
        expect_wb(1'b1, 5'd8, 32'h12345678);
        tick();
        dm = 32'h78563412;
        idle();
        #1;
        check_wb("lw");

        // Byte loads across every lane.
        drive(5'd9, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0, 4'b0100);
        expect_wb(1'b1, 5'd9, 32'hFFFFFFF0);
        tick();
        dm = 32'h00F00000;
        idle();
        #1;
        check_wb("lb_lane1_neg");

        drive(5'd10, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0, 4'b0001);
        expect_wb(1'b1, 5'd10, 32'h0000007F);
        tick();
        dm = 32'h0000007F;
        idle();
        #1;
        check_wb("lb_lane3_pos");

        drive(5'd11, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0, 4'b1000);
        expect_wb(1'b1, 5'd11, 32'hFFFFFF80);
        tick();
        dm = 32'h80000000;
        idle();
        #1;
        check_wb("lb_lane0_neg");

        drive(5'd13, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0, 4'b0010);
        expect_wb(1'b1, 5'd13, 32'hFFFFFFA5);
        tick();
        dm = 32'h0000A500;
        idle();
        #1;
        check_wb("lb_lane2_neg");

        drive(5'd14, 1'b1, 1'b0, 1'b1, 32'h55555555, 64'h0, 4'b0011);
        expect_wb(1'b1, 5'd14, 32'h0);
        tick();
        dm = 32'hFFFFFFFF;
        idle();
        #1;
        check_wb("bad_dre_zero");

        // ALU result path.
        drive(5'd3, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 64'h0, 4'b1111);
        expect_wb(1'b1, 5'd3, 32'hDEADBEEF);
        tick();
        dm = 32'h12345678;
        #1;
        check_wb("alu_result");

        // Load held by stall while the memory output changes.
        drive(5'd12, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0, 4'b1111);
        for (int i = 0; i < 4; i++) expect_wb(1'b1, 5'd12, 32'hDDCCBBAA);
        tick();
        dm = 32'hAABBCCDD;
        drive(5'd31, 1'b0, 1'b0, 1'b0, 32'h99999999, 64'h0, 4'b0000);
        stall = 1'b1;
        #1;
        check_wb("stall_load_first");
        for (int i = 0; i < 3; i++) begin
            tick();
            dm = 32'h0;
            #1;
            check_wb("stall_load_held");
        end

        // Stall and flush together with an ALU write pending.
        drive(5'd5, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 64'h0, 4'b0000);
        expect_wb(1'b1, 5'd5, 32'hCAFEF00D);
        expect_wb(1'b0, 5'd0, 32'h0);
        tick();
        check_wb("alu_before_flush");
        stall = 1'b1;
        flush = 1'b1;
        tick();
        check_wb("stall_flush_bubble");

        // Flush over a fresh load must not leak memory data.
        drive(5'd6, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0, 4'b1111);
        expect_wb(1'b0, 5'd0, 32'h0);
        tick();
        dm = 32'h01020304;
        idle();
        flush = 1'b1;
        tick();
        check_wb("flush_load_bubble");

        // HI/LO commit timing.
        drive(5'd0, 1'b0, 1'b1, 1'b0, 32'h0, 64'h00000001_FFFFFFFE, 4'b0000);
        tick();
        idle();
        #1;
`ifdef WB_HILO_BYPASS_EN
        check_hilo("hilo_wb_cycle", 32'h00000001, 32'hFFFFFFFE);
`else
        check_hilo("hilo_wb_cycle", 32'h0, 32'h0);
`endif
        tick();
        check_hilo("hilo_after_commit", 32'h00000001, 32'hFFFFFFFE);

        // Flush on the commit edge does not cancel the write.
        drive(5'd0, 1'b0, 1'b1, 1'b0, 32'h0, 64'hAAAA0000_00005555, 4'b0000);
        tick();
        idle();
        flush = 1'b1;
        tick();
        check_hilo("hilo_flush_same_edge", 32'hAAAA0000, 32'h00005555);
        flush = 1'b0;

        // Reset in the middle of a load.
        drive(5'd7, 1'b1, 1'b0, 1'b1, 32'h0, 64'h0, 4'b1111);
        tick();
        dm = 32'h11223344;
        idle();
        rst = 1'b1;
        #1;
        expect_wb(1'b0, 5'd0, 32'h0);
        check_wb("reset_mid_load");
        check_hilo("reset_mid_load_hilo", 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        expect_wb(1'b0, 5'd0, 32'h0);
        tick();
        check_wb("after_reset_no_write");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
